// File: rtl/usb_ep_buf_ctrl.sv
// Endpoint buffer controller: one IN and one OUT packet buffer, each handed
// between the application and the protocol engine by a two-state ownership FSM.
module usb_ep_buf_ctrl #(
    parameter  int DEPTH = 512,
    parameter  int LENW  = 10,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            ext_clk,
    input  logic            reset,
    // Application side, IN buffer
    input  logic [AW-1:0]   buf_in_addr,
    input  logic [7:0]      buf_in_data,
    input  logic            buf_in_wren,
    output logic            buf_in_ready,
    input  logic            buf_in_commit,
    input  logic [LENW-1:0] buf_in_commit_len,
    output logic            buf_in_commit_ack,
    // Application side, OUT buffer
    input  logic [AW-1:0]   buf_out_addr,
    output logic [7:0]      buf_out_q,
    output logic [LENW-1:0] buf_out_len,
    output logic            buf_out_hasdata,
    input  logic            buf_out_arm,
    output logic            buf_out_arm_ack,
    // Protocol engine side, IN buffer
    output logic            pe_in_valid,
    output logic [LENW-1:0] pe_in_len,
    input  logic [AW-1:0]   pe_in_rd_addr,
    output logic [7:0]      pe_in_rd_data,
    input  logic            pe_in_done,
    // Protocol engine side, OUT buffer
    output logic            pe_out_ready,
    input  logic            pe_out_wr_en,
    input  logic [AW-1:0]   pe_out_wr_addr,
    input  logic [7:0]      pe_out_wr_data,
    input  logic            pe_out_commit,
    input  logic [LENW-1:0] pe_out_commit_len
);

    typedef enum logic {IN_APP,   IN_CORE} in_state_e;
    typedef enum logic {OUT_CORE, OUT_APP} out_state_e;

    function automatic logic [LENW-1:0] clamp_len(input logic [LENW-1:0] len);
        return (len > LENW'(DEPTH)) ? LENW'(DEPTH) : len;
    endfunction

    in_state_e       in_state_q, in_state_d;
    logic [LENW-1:0] in_len_q, in_len_d;
    logic            in_ack_q, in_ack_d;

    out_state_e      out_state_q, out_state_d;
    logic [LENW-1:0] out_len_q, out_len_d;
    logic            out_ack_q, out_ack_d;

    logic [7:0] in_mem  [DEPTH];
    logic [7:0] out_mem [DEPTH];
    logic [7:0] in_rd_q, out_rd_q;

    // ---------------- IN ownership FSM ----------------
    always_comb begin
        in_state_d = in_state_q;
        in_len_d   = in_len_q;
        in_ack_d   = 1'b0;
        unique case (in_state_q)
            IN_APP: begin
                if (buf_in_commit) begin
                    in_state_d = IN_CORE;
                    in_len_d   = clamp_len(buf_in_commit_len);
                    in_ack_d   = 1'b1;
                end
            end
            IN_CORE: begin
                if (pe_in_done) in_state_d = IN_APP;
            end
            default: in_state_d = IN_APP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ext_clk) begin
        if (reset) begin
            in_state_q <= IN_APP;
            in_len_q   <= '0;
            in_ack_q   <= 1'b0;
        end else begin
            in_state_q <= in_state_d;
            in_len_q   <= in_len_d;
            in_ack_q   <= in_ack_d;
        end
    end

    // ---------------- OUT ownership FSM ----------------
    always_comb begin
        out_state_d = out_state_q;
        out_len_d   = out_len_q;
        out_ack_d   = buf_out_arm;  // arm is acknowledged in either state
        unique case (out_state_q)
            OUT_CORE: begin
                if (pe_out_commit) begin
                    out_state_d = OUT_APP;
                    out_len_d   = clamp_len(pe_out_commit_len);
                end
            end
            OUT_APP: begin
                if (buf_out_arm) out_state_d = OUT_CORE;
            end
            default: out_state_d = OUT_CORE;
        endcase
    end

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            out_state_q <= OUT_CORE;
            out_len_q   <= '0;
            out_ack_q   <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            out_len_q   <= out_len_d;
            out_ack_q   <= out_ack_d;
        end
    end

    // ---------------- Buffer RAMs ----------------
    // NOTE: RAM arrays carry no reset so they map onto block memory; only the read registers clear.
    always_ff @(posedge ext_clk) begin
        if (buf_in_wren && in_state_q == IN_APP)
            in_mem[buf_in_addr] <= buf_in_data;
        if (pe_out_wr_en && out_state_q == OUT_CORE)
            out_mem[pe_out_wr_addr] <= pe_out_wr_data;
    end

    // Registered reads see pre-edge contents, so a same-cycle write returns old data.
    always_ff @(posedge ext_clk) begin
        if (reset) begin
            in_rd_q  <= '0;
            out_rd_q <= '0;
        end else begin
            in_rd_q  <= in_mem[pe_in_rd_addr];
            out_rd_q <= out_mem[buf_out_addr];
        end
    end

    assign buf_in_ready      = (in_state_q == IN_APP);
    assign pe_in_valid       = (in_state_q == IN_CORE);
    assign pe_in_len         = in_len_q;
    assign buf_in_commit_ack = in_ack_q;
    assign pe_in_rd_data     = in_rd_q;

    assign pe_out_ready      = (out_state_q == OUT_CORE);
    assign buf_out_hasdata   = (out_state_q == OUT_APP);
    assign buf_out_len       = out_len_q;
    assign buf_out_arm_ack   = out_ack_q;
    assign buf_out_q         = out_rd_q;

endmodule

// File: tb/tb_usb_ep_buf_ctrl.sv
// Directed bench for usb_ep_buf_ctrl: round trips, lockouts, length clamping,
// mid-packet reset and spurious controls, against hand-computed values.
module tb_usb_ep_buf_ctrl;

    logic       ext_clk = 1'b0;
    logic       reset;
    logic [8:0] buf_in_addr;
    logic [7:0] buf_in_data;
    logic       buf_in_wren;
    logic       buf_in_ready;
    logic       buf_in_commit;
    logic [9:0] buf_in_commit_len;
    logic       buf_in_commit_ack;
    logic [8:0] buf_out_addr;
    logic [7:0] buf_out_q;
    logic [9:0] buf_out_len;
    logic       buf_out_hasdata;
    logic       buf_out_arm;
    logic       buf_out_arm_ack;
    logic       pe_in_valid;
    logic [9:0] pe_in_len;
    logic [8:0] pe_in_rd_addr;
    logic [7:0] pe_in_rd_data;
    logic       pe_in_done;
    logic       pe_out_ready;
    logic       pe_out_wr_en;
    logic [8:0] pe_out_wr_addr;
    logic [7:0] pe_out_wr_data;
    logic       pe_out_commit;
    logic [9:0] pe_out_commit_len;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ext_clk = ~ext_clk;

    usb_ep_buf_ctrl dut (
        .ext_clk           (ext_clk),
        .reset             (reset),
        .buf_in_addr       (buf_in_addr),
        .buf_in_data       (buf_in_data),
        .buf_in_wren       (buf_in_wren),
        .buf_in_ready      (buf_in_ready),
        .buf_in_commit     (buf_in_commit),
        .buf_in_commit_len (buf_in_commit_len),
        .buf_in_commit_ack (buf_in_commit_ack),
        .buf_out_addr      (buf_out_addr),
        .buf_out_q         (buf_out_q),
        .buf_out_len       (buf_out_len),
        .buf_out_hasdata   (buf_out_hasdata),
        .buf_out_arm       (buf_out_arm),
        .buf_out_arm_ack   (buf_out_arm_ack),
        .pe_in_valid       (pe_in_valid),
        .pe_in_len         (pe_in_len),
        .pe_in_rd_addr     (pe_in_rd_addr),
        .pe_in_rd_data     (pe_in_rd_data),
        .pe_in_done        (pe_in_done),
        .pe_out_ready      (pe_out_ready),
        .pe_out_wr_en      (pe_out_wr_en),
        .pe_out_wr_addr    (pe_out_wr_addr),
        .pe_out_wr_data    (pe_out_wr_data),
        .pe_out_commit     (pe_out_commit),
        .pe_out_commit_len (pe_out_commit_len)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic step();
        @(posedge ext_clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".in_ready"},  32'(buf_in_ready),      32'd1);
        check({tag, ".out_ready"}, 32'(pe_out_ready),      32'd1);
        check({tag, ".in_ack"},    32'(buf_in_commit_ack), 32'd0);
        check({tag, ".arm_ack"},   32'(buf_out_arm_ack),   32'd0);
        check({tag, ".hasdata"},   32'(buf_out_hasdata),   32'd0);
        check({tag, ".in_valid"},  32'(pe_in_valid),       32'd0);
    endtask

    initial begin
        reset = 1'b1;
        buf_in_addr = '0; buf_in_data = '0; buf_in_wren = 1'b0;
        buf_in_commit = 1'b0; buf_in_commit_len = '0;
        buf_out_addr = '0; buf_out_arm = 1'b0;
        pe_in_rd_addr = '0; pe_in_done = 1'b0;
        pe_out_wr_en = 1'b0; pe_out_wr_addr = '0; pe_out_wr_data = '0;
        pe_out_commit = 1'b0; pe_out_commit_len = '0;

        // Reset state
        step(); step();
        check_idle("rst");
        check("rst.out_len",  32'(buf_out_len),   32'd0);
        check("rst.in_len",   32'(pe_in_len),     32'd0);
        check("rst.out_q",    32'(buf_out_q),     32'd0);
        check("rst.in_rd",    32'(pe_in_rd_data), 32'd0);
        reset = 1'b0;
        step();
        check_idle("rst_after");

        // IN round trip: 0x00..0x3F at 0..63
        buf_in_wren = 1'b1;
        for (int i = 0; i < 64; i++) begin
            buf_in_addr = 9'(i); buf_in_data = 8'(i);
            step();
        end
        buf_in_wren = 1'b0;

        // Same-cycle write and read of addr 5 returns old data
        pe_in_rd_addr = 9'd5; buf_in_addr = 9'd5; buf_in_data = 8'h77; buf_in_wren = 1'b1;
        step();
        check("rdw.old", 32'(pe_in_rd_data), 32'h05);
        buf_in_wren = 1'b0;
        step();
        check("rdw.new", 32'(pe_in_rd_data), 32'h77);
        buf_in_addr = 9'd5; buf_in_data = 8'h05; buf_in_wren = 1'b1;
        step();
        buf_in_wren = 1'b0;

        buf_in_commit = 1'b1; buf_in_commit_len = 10'd64;
        step();
        buf_in_commit = 1'b0;
        check("in.ack",      32'(buf_in_commit_ack), 32'd1);
        check("in.ready",    32'(buf_in_ready),      32'd0);
        check("in.valid",    32'(pe_in_valid),       32'd1);
        check("in.len",      32'(pe_in_len),         32'd64);
        step();
        check("in.ack_end",  32'(buf_in_commit_ack), 32'd0);
        for (int i = 0; i < 64; i++) begin
            pe_in_rd_addr = 9'(i);
            step();
            check($sformatf("in.rd[%0d]", i), 32'(pe_in_rd_data), 32'(i));
        end

        // IN lockout while core owns the buffer
        buf_in_addr = 9'd0; buf_in_data = 8'hFF; buf_in_wren = 1'b1;
        buf_in_commit = 1'b1; buf_in_commit_len = 10'd5;
        step();
        buf_in_wren = 1'b0; buf_in_commit = 1'b0;
        check("lock.ack", 32'(buf_in_commit_ack), 32'd0);
        check("lock.len", 32'(pe_in_len),         32'd64);
        pe_in_rd_addr = 9'd0;
        step();
        check("lock.rd0", 32'(pe_in_rd_data), 32'h00);

        pe_in_done = 1'b1;
        step();
        pe_in_done = 1'b0;
        check("done.ready", 32'(buf_in_ready), 32'd1);
        check("done.valid", 32'(pe_in_valid),  32'd0);

        // Spurious done in IN_APP
        pe_in_done = 1'b1;
        step();
        pe_in_done = 1'b0;
        check("spur_done.ready", 32'(buf_in_ready), 32'd1);
        check("spur_done.valid", 32'(pe_in_valid),  32'd0);

        // Zero-length commit
        buf_in_commit = 1'b1; buf_in_commit_len = 10'd0;
        step();
        buf_in_commit = 1'b0;
        check("zlp.ack",   32'(buf_in_commit_ack), 32'd1);
        check("zlp.valid", 32'(pe_in_valid),       32'd1);
        check("zlp.len",   32'(pe_in_len),         32'd0);
        pe_in_done = 1'b1;
        step();
        pe_in_done = 1'b0;

        // Over-length commit clamps; held commit acked only once
        buf_in_commit = 1'b1; buf_in_commit_len = 10'd700;
        step();
        check("clamp.len",  32'(pe_in_len),         32'd512);
        check("hold.ack1",  32'(buf_in_commit_ack), 32'd1);
        step();
        check("hold.ack2",  32'(buf_in_commit_ack), 32'd0);
        step();
        buf_in_commit = 1'b0;
        check("hold.ack3",  32'(buf_in_commit_ack), 32'd0);
        check("hold.valid", 32'(pe_in_valid),       32'd1);
        pe_in_done = 1'b1;
        step();
        pe_in_done = 1'b0;

        // Write and commit in the same cycle at addr 511
        buf_in_addr = 9'd511; buf_in_data = 8'h5A; buf_in_wren = 1'b1;
        buf_in_commit = 1'b1; buf_in_commit_len = 10'd512;
        step();
        buf_in_wren = 1'b0; buf_in_commit = 1'b0;
        check("wc.valid", 32'(pe_in_valid), 32'd1);
        check("wc.len",   32'(pe_in_len),   32'd512);
        pe_in_rd_addr = 9'd511;
        step();
        check("wc.rd511", 32'(pe_in_rd_data), 32'h5A);
        pe_in_done = 1'b1;
        step();
        pe_in_done = 1'b0;

        // OUT round trip: 512 bytes of addr^0xA5
        check("out.ready0", 32'(pe_out_ready), 32'd1);
        pe_out_wr_en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] a;
            a = 9'(i);
            pe_out_wr_addr = a; pe_out_wr_data = a[7:0] ^ 8'hA5;
            step();
        end
        pe_out_wr_en = 1'b0;
        pe_out_commit = 1'b1; pe_out_commit_len = 10'd512;
        step();
        pe_out_commit = 1'b0;
        check("out.hasdata", 32'(buf_out_hasdata), 32'd1);
        check("out.len",     32'(buf_out_len),     32'd512);
        check("out.ready",   32'(pe_out_ready),    32'd0);
        for (int i = 0; i < 512; i++) begin
            logic [8:0] a;
            a = 9'(i);
            buf_out_addr = a;
            step();
            check($sformatf("out.q[%0d]", i), 32'(buf_out_q), 32'(a[7:0] ^ 8'hA5));
        end

        // OUT lockout while the application owns the buffer
        pe_out_wr_en = 1'b1; pe_out_wr_addr = 9'd0; pe_out_wr_data = 8'h00;
        pe_out_commit = 1'b1; pe_out_commit_len = 10'd3;
        step();
        pe_out_wr_en = 1'b0; pe_out_commit = 1'b0;
        check("olock.len", 32'(buf_out_len), 32'd512);
        buf_out_addr = 9'd0;
        step();
        check("olock.q0", 32'(buf_out_q), 32'hA5);

        // Arm releases the buffer
        buf_out_arm = 1'b1;
        step();
        buf_out_arm = 1'b0;
        check("arm.hasdata", 32'(buf_out_hasdata), 32'd0);
        check("arm.ack",     32'(buf_out_arm_ack), 32'd1);
        check("arm.ready",   32'(pe_out_ready),    32'd1);
        step();
        check("arm.ack_end", 32'(buf_out_arm_ack), 32'd0);

        // Spurious arm in OUT_CORE: ack but no state change
        buf_out_arm = 1'b1;
        step();
        buf_out_arm = 1'b0;
        check("sarm.ack",     32'(buf_out_arm_ack), 32'd1);
        check("sarm.ready",   32'(pe_out_ready),    32'd1);
        check("sarm.hasdata", 32'(buf_out_hasdata), 32'd0);
        step();
        check("sarm.ack_end", 32'(buf_out_arm_ack), 32'd0);

        // OUT clamp
        pe_out_commit = 1'b1; pe_out_commit_len = 10'd1023;
        step();
        pe_out_commit = 1'b0;
        check("oclamp.len", 32'(buf_out_len), 32'd512);

        // Mid-packet reset with IN_CORE, OUT_APP and a pending ack
        buf_in_commit = 1'b1; buf_in_commit_len = 10'd10;
        step();
        buf_in_commit = 1'b0;
        check("pre_rst.in_valid", 32'(pe_in_valid),     32'd1);
        check("pre_rst.hasdata",  32'(buf_out_hasdata), 32'd1);
        buf_out_arm = 1'b1;
        reset = 1'b1;
        step();
        buf_out_arm = 1'b0;
        check_idle("mid_rst");
        check("mid_rst.in_len", 32'(pe_in_len), 32'd0);
        reset = 1'b0;
        step();
        check_idle("mid_rst_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
